alu_control_seq: RTL and testbench

Registered, handshaked successor to the combinational ALU control decoder. Decodes ALUOp/funct into the ALU control code and sequences multi-cycle multiply/divide operations with a counter-driven FSM, stalling the issue stage via `in_ready`/`busy`. Sits between the main control unit / ID-EX register and the ALU / mul-div unit.

---
 rtl/alu_control_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_control_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a counter-driven IDLE/BUSY sequencer that
// stalls issue for the duration of multi-cycle multiply/divide operations.
module alu_control_seq #(
   parameter int ALUOP_W    = 4,
   parameter int FUNC_W     = 6,
   parameter int CTL_W      = 4,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ALUOP_W-1:0] alu_op,
   input  logic [FUNC_W-1:0]  func,
   input  logic               flush,
   output logic [CTL_W-1:0]   ctl,
   output logic               ctl_valid,
   output logic               ctl_multi,
   output logic               illegal,
   output logic               busy,
   output logic               done
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [CTL_W-1:0] NOP      = '1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [CTL_W-1:0]   ctl_reg, ctl_next;
   logic               ctl_valid_reg, ctl_valid_next;
   logic               ctl_multi_reg, ctl_multi_next;
   logic               illegal_reg, illegal_next;

   logic [CTL_W-1:0]   dec_code;
   logic               dec_illegal;
   logic               dec_multi;
   logic [CNT_W-1:0]   dec_load;
   logic               accept;

   // Instruction decode; jr is a legal NOP, unknown encodings are flagged NOPs.
   always_comb begin
      dec_code    = NOP;
      dec_illegal = 1'b0;
      dec_multi   = 1'b0;
      dec_load    = '0;
      case (alu_op)
         ALUOP_W'(0): dec_code = CTL_W'(4'd2);
         ALUOP_W'(1): dec_code = CTL_W'(4'd6);
         ALUOP_W'(3): dec_code = CTL_W'(4'd2);
         ALUOP_W'(4): dec_code = CTL_W'(4'd7);
         ALUOP_W'(5): dec_code = CTL_W'(4'd0);
         ALUOP_W'(6): dec_code = CTL_W'(4'd1);
         ALUOP_W'(7): dec_code = CTL_W'(4'd11);
         ALUOP_W'(2): begin
            case (func)
               FUNC_W'(0):  dec_code = CTL_W'(4'd13);
               FUNC_W'(2):  dec_code = CTL_W'(4'd14);
               FUNC_W'(8):  dec_code = NOP;
               FUNC_W'(32): dec_code = CTL_W'(4'd2);
               FUNC_W'(34): dec_code = CTL_W'(4'd6);
               FUNC_W'(36): dec_code = CTL_W'(4'd0);
               FUNC_W'(37): dec_code = CTL_W'(4'd1);
               FUNC_W'(39): dec_code = CTL_W'(4'd12);
               FUNC_W'(42): dec_code = CTL_W'(4'd7);
               FUNC_W'(24): begin
                  dec_code  = CTL_W'(4'd3);
                  dec_multi = 1'b1;
                  dec_load  = MUL_LOAD;
               end
               FUNC_W'(25): begin
                  dec_code  = CTL_W'(4'd4);
                  dec_multi = 1'b1;
                  dec_load  = MUL_LOAD;
               end
               FUNC_W'(26): begin
                  dec_code  = CTL_W'(4'd5);
                  dec_multi = 1'b1;
                  dec_load  = DIV_LOAD;
               end
               FUNC_W'(27): begin
                  dec_code  = CTL_W'(4'd9);
                  dec_multi = 1'b1;
                  dec_load  = DIV_LOAD;
               end
               default: dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign accept = in_valid && (state_reg == IDLE) && !flush;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      ctl_next       = ctl_reg;
      ctl_valid_next = ctl_valid_reg;
      ctl_multi_next = ctl_multi_reg;
      illegal_next   = illegal_reg;
      if (flush) begin
         // Abort: the code itself is kept, only its qualifiers are dropped.
         state_next     = IDLE;
         cnt_next       = '0;
         ctl_valid_next = 1'b0;
         ctl_multi_next = 1'b0;
         illegal_next   = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  ctl_next       = dec_code;
                  illegal_next   = dec_illegal;
                  ctl_valid_next = 1'b1;
                  ctl_multi_next = dec_multi;
                  if (dec_multi) begin
                     state_next = BUSY;
                     cnt_next   = dec_load;
                  end
               end else begin
                  ctl_valid_next = 1'b0;
                  ctl_multi_next = 1'b0;
               end
            end
            BUSY: begin
               if (cnt_reg == '0) begin
                  state_next     = IDLE;
                  ctl_valid_next = 1'b0;
                  ctl_multi_next = 1'b0;
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         ctl_reg       <= NOP;
         ctl_valid_reg <= 1'b0;
         ctl_multi_reg <= 1'b0;
         illegal_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         ctl_reg       <= ctl_next;
         ctl_valid_reg <= ctl_valid_next;
         ctl_multi_reg <= ctl_multi_next;
         illegal_reg   <= illegal_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg == BUSY);
   assign done      = (state_reg == BUSY) && (cnt_reg == '0);
   assign ctl       = ctl_reg;
   assign ctl_valid = ctl_valid_reg;
   assign ctl_multi = ctl_multi_reg;
   assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a remaining-cycles reference model.
module tb_alu_control_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] alu_op = '0;
   logic [5:0] func = '0;
   logic       flush = 1'b0;
   logic [3:0] ctl;
   logic       ctl_valid, ctl_multi, illegal, busy, done;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   alu_control_seq #(
      .ALUOP_W(4), .FUNC_W(6), .CTL_W(4),
      .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .func(func), .flush(flush), .ctl(ctl),
      .ctl_valid(ctl_valid), .ctl_multi(ctl_multi), .illegal(illegal),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference decode straight from the ALUOp and funct tables.
   function automatic void ref_dec(input int op, input int f,
                                   output int code, output bit ill, output int cyc);
      int op_tab[8] = '{2, 6, -1, 2, 7, 0, 1, 11};
      code = 15; ill = 1'b0; cyc = 0;
      if (op > 7) ill = 1'b1;
      else if (op != 2) code = op_tab[op];
      else begin
         case (f)
            0: code = 13;   2: code = 14;   8: code = 15;
            32: code = 2;   34: code = 6;   36: code = 0;
            37: code = 1;   39: code = 12;  42: code = 7;
            24: begin code = 3; cyc = 4;  end
            25: begin code = 4; cyc = 4;  end
            26: begin code = 5; cyc = 32; end
            27: begin code = 9; cyc = 32; end
            default: ill = 1'b1;
         endcase
      end
   endfunction

   // Model: rem = busy cycles still to be shown (0 means idle).
   int m_rem = 0;
   int m_ctl = 15;
   bit m_valid = 0, m_multi = 0, m_ill = 0;

   always @(posedge clk or negedge rst_n) begin
      int code, cyc;
      bit ill;
      if (!rst_n) begin
         m_rem = 0; m_ctl = 15; m_valid = 0; m_multi = 0; m_ill = 0;
      end else if (flush) begin
         m_rem = 0; m_valid = 0; m_multi = 0; m_ill = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin m_valid = 0; m_multi = 0; end
      end else if (in_valid) begin
         ref_dec(int'(alu_op), int'(func), code, ill, cyc);
         m_ctl = code; m_ill = ill; m_valid = 1; m_multi = (cyc > 0); m_rem = cyc;
      end else begin
         m_valid = 0; m_multi = 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ctl", int'(ctl), m_ctl);
         check("ctl_valid", int'(ctl_valid), int'(m_valid));
         check("ctl_multi", int'(ctl_multi), int'(m_multi));
         check("busy", int'(busy), int'(m_rem > 0));
         check("done", int'(done), int'(m_rem == 1));
         check("in_ready", int'(in_ready), int'(m_rem == 0));
         if (m_valid) check("illegal", int'(illegal), int'(m_ill));
      end
   end

   // Apply inputs for one edge; returns mid-cycle after that edge.
   task automatic drive(input logic v, input int op, input int f, input logic fl);
      in_valid = v; alu_op = 4'(op); func = 6'(f); flush = fl;
      @(negedge clk);
   endtask

   initial begin
      int fb2b[8] = '{32, 34, 36, 37, 39, 42, 0, 2};
      int cb2b[8] = '{2, 6, 0, 1, 12, 7, 13, 14};
      int flist[15] = '{0, 2, 8, 32, 34, 36, 37, 39, 42, 24, 25, 26, 27, 50, 1};

      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      @(negedge clk);
      check("rst_ctl", int'(ctl), 15);
      check("rst_valid", int'(ctl_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      drive(1, 0, 0, 0);
      check("op0_ctl", int'(ctl), 2);
      check("op0_valid", int'(ctl_valid), 1);
      drive(0, 0, 0, 0);
      check("op0_valid_fall", int'(ctl_valid), 0);
      check("op0_ctl_hold", int'(ctl), 2);

      for (int i = 0; i < 8; i++) begin
         drive(1, 2, fb2b[i], 0);
         check("b2b_ctl", int'(ctl), cb2b[i]);
         check("b2b_illegal", int'(illegal), 0);
         check("b2b_ready", int'(in_ready), 1);
      end

      // Multiply with a pending request held during busy.
      drive(1, 2, 24, 0);
      alu_op = 4'd0; func = 6'd0;
      for (int i = 1; i <= 4; i++) begin
         check("mul_ctl", int'(ctl), 3);
         check("mul_busy", int'(busy), 1);
         check("mul_done", int'(done), int'(i == 4));
         check("mul_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      check("mul_ready_back", int'(in_ready), 1);
      check("mul_busy_off", int'(busy), 0);
      @(negedge clk);
      check("mul_next_ctl", int'(ctl), 2);
      check("mul_next_valid", int'(ctl_valid), 1);
      in_valid = 1'b0;

      // Divide aborted in busy cycle 10; flush beats the concurrent request.
      drive(1, 2, 26, 0);
      in_valid = 1'b0;
      for (int i = 1; i < 10; i++) begin
         check("div_done_early", int'(done), 0);
         @(negedge clk);
      end
      check("div_busy_c10", int'(busy), 1);
      drive(1, 0, 0, 1);
      check("flush_busy", int'(busy), 0);
      check("flush_valid", int'(ctl_valid), 0);
      check("flush_ready", int'(in_ready), 1);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 25; i++) begin
         check("flush_no_done", int'(done), 0);
         @(negedge clk);
      end

      drive(1, 9, 0, 0);
      check("ill_op_ctl", int'(ctl), 15);
      check("ill_op_flag", int'(illegal), 1);
      drive(1, 2, 8, 0);
      check("jr_ctl", int'(ctl), 15);
      check("jr_flag", int'(illegal), 0);
      drive(1, 2, 50, 0);
      check("ill_f_flag", int'(illegal), 1);

      // Asynchronous reset in divide cycle 5, between clock edges.
      drive(1, 2, 27, 0);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_valid", int'(ctl_valid), 0);
      check("arst_ready", int'(in_ready), 1);
      check("arst_ctl", int'(ctl), 15);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 4, 0, 0);
      check("arst_after_ctl", int'(ctl), 7);
      check("arst_after_valid", int'(ctl_valid), 1);

      for (int n = 0; n < 2500; n++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         alu_op   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
         func     = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                : 6'(flist[$urandom_range(0, 14)]);
         flush    = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end

      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
